mac_array_sequencer: RTL and testbench

- Sequences an N x N output-stationary grid of fp16 processing_unit MAC cells.
- On a start command it clears the accumulators and streams K operand pairs from the A/B operand buffers onto broadcast row and column buses.
- It then flushes the PE pipeline and drains the N x N result tile row by row over a valid/ready port.
- It sits between the TPU command path and the PE array.

---
 rtl/mac_array_sequencer_if.sv | 13 +
 rtl/mac_array_sequencer.sv | 103 ++++++++++
 tb/tb_mac_array_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_array_sequencer_if.sv
// Result drain port of the MAC array sequencer: one tile row per valid/ready beat.
interface mac_array_sequencer_if #(
  parameter int N  = 4,
  parameter int DW = 16
);
  logic                 res_valid;
  logic                 res_ready;
  logic [$clog2(N)-1:0] res_row;
  logic [N*DW-1:0]      res_data;

  modport master (output res_valid, res_row, res_data, input res_ready);
  modport slave  (input res_valid, res_row, res_data, output res_ready);
endinterface

// File: rtl/mac_array_sequencer.sv
// Sequences an N x N output-stationary fp16 MAC grid: clear, stream K operand
// pairs on broadcast buses, flush the PE pipeline, then drain the tile row by row.
module mac_array_sequencer #(
  parameter int  N      = 4,
  parameter int  DW     = 16,
  parameter int  K_MAX  = 16,
  parameter int  PE_LAT = 2,
  localparam int KW     = $clog2(K_MAX + 1),
  localparam int AW     = $clog2(K_MAX),
  localparam int RW     = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                a_rd_en,
  output logic [AW-1:0]       a_rd_addr,
  input  logic [N*DW-1:0]     a_rd_data,
  output logic                b_rd_en,
  output logic [AW-1:0]       b_rd_addr,
  input  logic [N*DW-1:0]     b_rd_data,
  output logic                pe_clear,
  output logic                pe_en,
  output logic [N*DW-1:0]     pe_a,
  output logic [N*DW-1:0]     pe_b,
  input  logic [N*N*DW-1:0]   pe_p,
  mac_array_sequencer_if.master res
);
  localparam int FW = $clog2(PE_LAT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, COMPUTE, FLUSH, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_len_q, k_q;
  logic [FW-1:0] fl_q;
  logic [RW-1:0] row_q;
  logic          rd_q, err_q;
  logic          k_ok, accept;

  assign k_ok   = (k_len != '0) && (k_len <= KW'(K_MAX));
  assign accept = (state_q == DRAIN) && res.res_ready;

  always_comb begin
    // NOTE: state_d gets its default before the case so every path assigns it and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && k_ok) state_d = CLEAR;
      CLEAR:   state_d = COMPUTE;
      COMPUTE: if (k_q == k_len_q) state_d = FLUSH;
      FLUSH:   if (fl_q == FW'(PE_LAT - 1)) state_d = DRAIN;
      DRAIN:   if (accept && row_q == RW'(N - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort overrides whatever the current state would have done.
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      k_len_q <= '0;
      k_q     <= '0;
      fl_q    <= '0;
      row_q   <= '0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start && !k_ok;
      // Operand data arrives one cycle after the read strobe; an abort drops it.
      rd_q    <= a_rd_en && (state_d == COMPUTE);
      if (state_q == IDLE && state_d == CLEAR) k_len_q <= k_len;
      k_q  <= (state_q == COMPUTE && state_d == COMPUTE) ? k_q + 1'b1 : '0;
      fl_q <= (state_q == FLUSH && state_d == FLUSH) ? fl_q + 1'b1 : '0;
      if (state_d != DRAIN)  row_q <= '0;
      else if (accept)       row_q <= row_q + 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign pe_clear  = (state_q == CLEAR);
  assign a_rd_en   = (state_q == COMPUTE) && (k_q != k_len_q);
  assign b_rd_en   = a_rd_en;
  assign a_rd_addr = k_q[AW-1:0];
  assign b_rd_addr = k_q[AW-1:0];

  // Flush keeps the array clocked with +0.0 operands so in-flight products commit.
  assign pe_en = rd_q || (state_q == FLUSH);
  assign pe_a  = rd_q ? a_rd_data : '0;
  assign pe_b  = rd_q ? b_rd_data : '0;

  assign res.res_valid = (state_q == DRAIN);
  assign res.res_row   = row_q;
  assign res.res_data  = pe_p[int'(row_q)*N*DW +: N*DW];
endmodule

// File: tb/tb_mac_array_sequencer.sv
// Randomized bench for mac_array_sequencer: models operand buffers and a PE grid,
// predicts each tile as a plain integer matrix product encoded as fp16.
module tb_mac_array_sequencer;
  localparam int N      = 4;
  localparam int DW     = 16;
  localparam int K_MAX  = 16;
  localparam int PE_LAT = 2;
  localparam int KW     = $clog2(K_MAX + 1);
  localparam int AW     = $clog2(K_MAX);

  logic              clk = 1'b0;
  logic              reset, start, abort;
  logic [KW-1:0]     k_len;
  logic              busy, done, err;
  logic              a_rd_en, b_rd_en;
  logic [AW-1:0]     a_rd_addr, b_rd_addr;
  logic [N*DW-1:0]   a_rd_data, b_rd_data;
  logic              pe_clear, pe_en;
  logic [N*DW-1:0]   pe_a, pe_b;
  logic [N*N*DW-1:0] pe_p;

  mac_array_sequencer_if #(.N(N), .DW(DW)) res_if ();

  mac_array_sequencer #(.N(N), .DW(DW), .K_MAX(K_MAX), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .pe_clear(pe_clear), .pe_en(pe_en), .pe_a(pe_a), .pe_b(pe_b), .pe_p(pe_p),
    .res(res_if.master)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int pe_en_cnt = 0, pe_clear_cnt = 0, err_cnt = 0, done_cnt = 0, rd_total = 0, ab_skew = 0;
  int rd_hits [K_MAX];
  int a_mem [K_MAX][N];   // a_mem[k][i] = A[i][k]
  int b_mem [K_MAX][N];   // b_mem[k][j] = B[k][j]
  int acc [N][N];
  int prod [N][N];
  logic [N*DW-1:0] got_rows [N];

  // fp16 encode/decode restricted to non-negative integers up to 2047.
  function automatic logic [15:0] enc(input int v);
    int e;
    if (v == 0) return 16'h0000;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    return {1'b0, 5'(e + 15), 10'((v << (10 - e)) & 'h3FF)};
  endfunction

  function automatic int dec(input logic [15:0] h);
    int e;
    if (h[14:0] == 15'd0) return 0;
    e = int'(h[14:10]) - 15;
    return (1024 + int'(h[9:0])) >> (10 - e);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Operand buffers: synchronous read, data one cycle after the strobe.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (a_rd_en) a_rd_data[i*DW +: DW] <= enc(a_mem[a_rd_addr][i]);
      if (b_rd_en) b_rd_data[i*DW +: DW] <= enc(b_mem[b_rd_addr][i]);
    end
  end

  // PE grid: product registered, then accumulated; both stages advance only with pe_en.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (pe_clear) begin
          acc[i][j]  <= 0;
          prod[i][j] <= 0;
        end else if (pe_en) begin
          acc[i][j]  <= acc[i][j] + prod[i][j];
          prod[i][j] <= dec(pe_a[i*DW +: DW]) * dec(pe_b[j*DW +: DW]);
        end
  end

  always_comb begin
    pe_p = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        pe_p[(i*N + j)*DW +: DW] = enc(acc[i][j]);
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (pe_en)    pe_en_cnt++;
    if (pe_clear) pe_clear_cnt++;
    if (err)      err_cnt++;
    if (done)     done_cnt++;
    if (a_rd_en) begin
      rd_total++;
      rd_hits[a_rd_addr]++;
    end
    if (a_rd_en !== b_rd_en || (a_rd_en && a_rd_addr !== b_rd_addr)) ab_skew++;
  end

  task automatic fill(input int mode);
    for (int k = 0; k < K_MAX; k++)
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: begin a_mem[k][i] = 1; b_mem[k][i] = 2; end
          1: begin a_mem[k][i] = (k == i) ? 1 : 0; b_mem[k][i] = int'($urandom_range(0, 7)); end
          2: begin a_mem[k][i] = int'($urandom_range(0, 3)); b_mem[k][i] = int'($urandom_range(0, 3)); end
          default: begin a_mem[k][i] = 1; b_mem[k][i] = 1; end
        endcase
      end
  endtask

  // mode 0: ready always high, 1: fixed stall pattern, 2: random ready.
  task automatic run_tile(input int k, input int mode, input string nm);
    logic [N*DW-1:0] exp_rows [N];
    logic [7:0]      pat;
    logic [1:0]      st_row;
    logic [N*DW-1:0] st_data;
    int h0 [K_MAX];
    int en0, clr0, rd0, sk0, dn0, t0, t_done, rows, drain_n, bad, sum;
    bit stalled, fin, rdy;
    pat = 8'b1011_0100;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        sum = 0;
        for (int kk = 0; kk < k; kk++) sum += a_mem[kk][i] * b_mem[kk][j];
        exp_rows[i][j*DW +: DW] = enc(sum);
      end
    for (int a = 0; a < K_MAX; a++) h0[a] = rd_hits[a];
    en0 = pe_en_cnt; clr0 = pe_clear_cnt; rd0 = rd_total; sk0 = ab_skew; dn0 = done_cnt;
    rows = 0; drain_n = 0; stalled = 0; fin = 0; t_done = 0;
    st_row = '0; st_data = '0;
    @(negedge clk);
    start = 1'b1; k_len = KW'(k); res_if.res_ready = 1'b0; t0 = cyc;
    for (int n = 0; n < 300 && !fin; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        fin = 1; t_done = cyc;
      end else if (res_if.res_valid) begin
        if (stalled) begin
          check({nm, "_hold_row"}, res_if.res_row, st_row);
          check({nm, "_hold_data"}, res_if.res_data, st_data);
        end
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (drain_n < 8) ? pat[drain_n] : 1'b1;
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        drain_n++;
        res_if.res_ready = rdy;
        if (rdy) begin
          check({nm, "_row"}, res_if.res_row, rows);
          check({nm, "_data"}, res_if.res_data, exp_rows[rows % N]);
          got_rows[rows % N] = res_if.res_data;
          rows++;
          stalled = 0;
        end else begin
          stalled = 1; st_row = res_if.res_row; st_data = res_if.res_data;
        end
      end
    end
    res_if.res_ready = 1'b0;
    if (!fin) check({nm, "_timeout"}, 0, 1);
    check({nm, "_rows"}, rows, N);
    if (mode == 0) check({nm, "_latency"}, t_done - t0, k + PE_LAT + N + 3);
    check({nm, "_pe_en_cycles"}, pe_en_cnt - en0, k + PE_LAT);
    check({nm, "_pe_clear_cycles"}, pe_clear_cnt - clr0, 1);
    check({nm, "_reads"}, rd_total - rd0, k);
    check({nm, "_ab_skew"}, ab_skew - sk0, 0);
    bad = 0;
    for (int a = 0; a < K_MAX; a++)
      if (rd_hits[a] - h0[a] != ((a < k) ? 1 : 0)) bad++;
    check({nm, "_addr_once"}, bad, 0);
    @(negedge clk);
    @(negedge clk);
    check({nm, "_done_pulses"}, done_cnt - dn0, 1);
    check({nm, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int d0, e0, r0, guard;
    bit found;
    for (int a = 0; a < K_MAX; a++) rd_hits[a] = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0; res_if.res_ready = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_pe_en", pe_en, 0);
    check("rst_pe_clear", pe_clear, 0);
    check("rst_rd_en", a_rd_en, 0);
    check("rst_res_valid", res_if.res_valid, 0);
    check("rst_pe_a", pe_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1.0 * 2.0 over K=4 -> 8.0 everywhere.
    fill(0);
    run_tile(4, 0, "ones");
    check("ones_tile_8", got_rows[2], {N{16'h4800}});

    // Identity A reproduces B row for row.
    fill(1);
    run_tile(4, 0, "ident");
    check("ident_row3_eq_b", got_rows[3],
          {enc(b_mem[3][3]), enc(b_mem[3][2]), enc(b_mem[3][1]), enc(b_mem[3][0])});

    // Rejected starts.
    e0 = err_cnt; r0 = rd_total;
    @(negedge clk); start = 1'b1; k_len = KW'(0);
    @(negedge clk); start = 1'b0;
    check("err_k0", err, 1);
    check("err_k0_busy", busy, 0);
    @(negedge clk); check("err_k0_pulse", err, 0);
    start = 1'b1; k_len = KW'(17);
    @(negedge clk); start = 1'b0;
    check("err_k17", err, 1);
    check("err_k17_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    check("err_pulse_count", err_cnt - e0, 2);
    check("err_no_reads", rd_total - r0, 0);

    // K = K_MAX, 16 x 1.0*1.0 = 16.0.
    fill(3);
    run_tile(16, 0, "kmax");
    check("kmax_tile_16", got_rows[0], {N{16'h4C00}});

    // Backpressure with the fixed ready pattern.
    fill(2);
    run_tile(int'($urandom_range(1, K_MAX)), 1, "bp");

    // Abort at COMPUTE cycle 2, with a start that must be ignored.
    fill(0);
    d0 = done_cnt;
    @(negedge clk); start = 1'b1; k_len = KW'(4);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_at_k2", a_rd_addr, 2);
    abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_rd_en", a_rd_en, 0);
    check("abort_pe_en", pe_en, 0);
    repeat (3) @(negedge clk);
    check("abort_still_idle", busy, 0);
    check("abort_no_done", done_cnt - d0, 0);
    run_tile(2, 0, "post_abort");
    check("post_abort_tile_4", got_rows[3], {N{16'h4400}});

    // Reset while row 1 is being presented.
    fill(2);
    d0 = done_cnt; found = 0; guard = 0;
    @(negedge clk); start = 1'b1; k_len = KW'(2); res_if.res_ready = 1'b1;
    while (!found && guard < 100) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      if (res_if.res_valid && res_if.res_row == 2'd1) found = 1;
    end
    if (!found) check("mid_reset_reach_row1", 0, 1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; res_if.res_ready = 1'b0;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_valid", res_if.res_valid, 0);
    check("mid_reset_pe_en", pe_en, 0);
    repeat (3) @(negedge clk);
    check("mid_reset_no_done", done_cnt - d0, 0);
    fill(0);
    run_tile(2, 0, "post_reset");
    check("post_reset_tile_4", got_rows[0], {N{16'h4400}});

    // Random tiles, random K, random ready.
    for (int r = 0; r < 6; r++) begin
      fill(2);
      run_tile(int'($urandom_range(1, K_MAX)), 2, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
